// File: rtl/oht2bin_pkg.sv
// oht2bin_pkg -- shared types and helpers for the pipelined one-hot encoder.
//   IDX_MAX       : widest internal index a group record can carry.
//   oht2bin_rec_t : per-group record {any, idx, err}. idx is sized for the
//                   worst case. Bits above a level's real index width stay 0
//                   and are removed by synthesis.
//   levels()      : number of tree levels = ceil(clog2(width)/clog2(split)).
package oht2bin_pkg;

    localparam int IDX_MAX = 32;

    typedef struct packed {
        logic               any;
        logic [IDX_MAX-1:0] idx;
        logic               err;
    } oht2bin_rec_t;

    function automatic int levels(input int width, input int split);
        int wl;
        int sl;
        wl = $clog2(width);
        sl = $clog2(split);
        // Guard the divide so a bad SPLIT reaches the top-level $error check.
        if (sl < 1) sl = 1;
        return (wl + sl - 1) / sl;
    endfunction

endpackage

// File: rtl/oht2bin_base.sv
// oht2bin_base -- combinational SPLIT-to-1 group combiner.
//   child  : SPLIT child records. A child whose any=0 carries idx=0.
//   parent : merged record.
//            any = OR of child any.
//            idx = {encode(child any), OR of child idx}. The encoded part is
//                  placed above the CW bits that the children already hold.
//            err = OR of child err, or more than one child any set.
// Build macro OHT2BIN_PIPE_ERR_CHECK_EN: when it is undefined, err is forced to 0.
module oht2bin_base
    import oht2bin_pkg::*;
#(
    parameter int SPLIT = 2,
    parameter int CW    = 0   // index bits already resolved by the children
) (
    input  oht2bin_rec_t [SPLIT-1:0] child,
    output oht2bin_rec_t             parent
);

`ifdef OHT2BIN_PIPE_ERR_CHECK_EN
    logic seen;
`else
    logic [SPLIT-1:0] unused_err;
    for (genvar i = 0; i < SPLIT; i++) begin : g_unused
        assign unused_err[i] = child[i].err;
    end
`endif

    // OR-encoding: a non-one-hot group yields the OR of the set positions.
    // This is the documented behaviour when the check is disabled.
    always_comb begin
        parent = '0;
`ifdef OHT2BIN_PIPE_ERR_CHECK_EN
        seen = 1'b0;
`endif
        for (int i = 0; i < SPLIT; i++) begin
            parent.idx = parent.idx | child[i].idx;
            if (child[i].any) begin
                parent.any = 1'b1;
                parent.idx = parent.idx | (IDX_MAX'(i) << CW);
`ifdef OHT2BIN_PIPE_ERR_CHECK_EN
                if (seen) parent.err = 1'b1;
                seen = 1'b1;
`endif
            end
`ifdef OHT2BIN_PIPE_ERR_CHECK_EN
            parent.err = parent.err | child[i].err;
`endif
        end
    end

endmodule

// File: rtl/oht2bin_pipe.sv
// oht2bin_pipe -- pipelined one-hot to binary encoder with valid/ready per level.
//   clk, rst      : clock, synchronous active-high reset.
//   i_vld/i_rdy   : input handshake. oht is the WIDTH-bit one-hot vector.
//                   An all-zero vector is a legal beat.
//   o_vld/o_rdy   : output handshake.
//   bin           : encoded index.
//   any           : at least one bit was set.
//   err           : more than one bit was set.
// The oht vector is zero-padded to POWER = SPLIT**LEVELS bits. It is then reduced by
// LEVELS registered levels of oht2bin_base groups.
// Build macro OHT2BIN_PIPE_ERR_CHECK_EN enables err. When it is undefined, err is
// tied to 0. The constant err flops are then removed by synthesis.
module oht2bin_pipe
    import oht2bin_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int SPLIT     = 2,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_vld,
    output logic                 i_rdy,
    input  logic [WIDTH-1:0]     oht,
    output logic                 o_vld,
    input  logic                 o_rdy,
    output logic [WIDTH_LOG-1:0] bin,
    output logic                 any,
    output logic                 err
);

    localparam int SPLIT_LOG = $clog2(SPLIT);
    localparam int LEVELS    = levels(WIDTH, SPLIT);
    localparam int IDX_W     = LEVELS * SPLIT_LOG;
    localparam int POWER     = 1 << IDX_W;   // == SPLIT**LEVELS for power-of-2 SPLIT

    if (SPLIT < 2 || (SPLIT & (SPLIT - 1)) != 0) begin : g_bad_split
        $error("oht2bin_pipe: SPLIT must be a power of 2 and >= 2");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("oht2bin_pipe: WIDTH must be >= 2");
    end
    if (IDX_W > IDX_MAX) begin : g_bad_idx
        $error("oht2bin_pipe: internal index exceeds IDX_MAX");
    end

    logic [POWER-1:0] oht_pad;
    logic [LEVELS:0]  vld_pipe;   // [0] = input valid, [l+1] = level l valid
    logic [LEVELS:0]  rdy;        // [l] = level l can accept, [LEVELS] = o_rdy

    assign oht_pad     = POWER'(oht);
    assign vld_pipe[0] = i_vld;

    // A level accepts when it is empty or the level downstream takes its beat.
    always_comb begin
        rdy         = '0;
        rdy[LEVELS] = o_rdy;
        for (int l = LEVELS - 1; l >= 0; l--) begin
            rdy[l] = !vld_pipe[l+1] || rdy[l+1];
        end
    end

    assign i_rdy = rdy[0];

    for (genvar l = 0; l < LEVELS; l++) begin : lvl
        localparam int NG = POWER >> ((l + 1) * SPLIT_LOG);

        oht2bin_rec_t [NG*SPLIT-1:0] ch;
        oht2bin_rec_t [NG-1:0]       nxt;
        oht2bin_rec_t [NG-1:0]       q;
        logic                        v;

        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < POWER; i++) begin : g_bit
                assign ch[i] = '{any: oht_pad[i], idx: '0, err: 1'b0};
            end
        end else begin : g_node
            assign ch = lvl[l-1].q;
        end

        for (genvar g = 0; g < NG; g++) begin : grp
            oht2bin_base #(
                .SPLIT (SPLIT),
                .CW    (l * SPLIT_LOG)
            ) u_base (
                .child  (ch[g*SPLIT +: SPLIT]),
                .parent (nxt[g])
            );
        end

        // When the level is ready, it takes the upstream valid bit. This one rule
        // covers load, drain-and-refill (v stays 1) and drain without refill (v clears).
        // Data stays unchanged on bubbles.
        always_ff @(posedge clk) begin
            if (rst) begin
                v <= 1'b0;
                q <= '0;
            end else if (rdy[l]) begin
                v <= vld_pipe[l];
                if (vld_pipe[l]) q <= nxt;
            end
        end

        assign vld_pipe[l+1] = v;
    end

    oht2bin_rec_t out_rec;
    assign out_rec = lvl[LEVELS-1].q[0];

    assign o_vld = vld_pipe[LEVELS];
    assign bin   = out_rec.idx[WIDTH_LOG-1:0];
    assign any   = out_rec.any;

`ifdef OHT2BIN_PIPE_ERR_CHECK_EN
    logic unused_rec;
    assign unused_rec = ^out_rec.idx[IDX_MAX-1:WIDTH_LOG];
    assign err        = out_rec.err;
`else
    logic unused_rec;
    assign unused_rec = ^{out_rec.idx[IDX_MAX-1:WIDTH_LOG], out_rec.err};
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_oht2bin_pipe.sv
// tb_oht2bin_pipe -- self-checking bench for oht2bin_pipe.
// DUT a: WIDTH=32, SPLIT=2 (5 levels). DUT b: WIDTH=20, SPLIT=4 (3 levels).
// Expected results come from a table, or from a popcount/OR-of-indices model
// of the input vector. A queue matches results to beats in order.
module tb_oht2bin_pipe;

`ifdef OHT2BIN_PIPE_ERR_CHECK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    typedef logic [6:0] res_t;   // {err, any, bin}
    typedef struct {
        logic [31:0] oht;
        res_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_vld = 1'b0, i_rdy, o_vld, o_rdy = 1'b0, any, err;
    logic [31:0] oht = '0;
    logic [4:0]  bin;

    logic        i_vld_b = 1'b0, i_rdy_b, o_vld_b, o_rdy_b = 1'b1, any_b, err_b;
    logic [19:0] oht_b = '0;
    logic [4:0]  bin_b;

    always #5 clk = ~clk;

    oht2bin_pipe #(.WIDTH(32), .SPLIT(2)) u_dut_a (
        .clk(clk), .rst(rst), .i_vld(i_vld), .i_rdy(i_rdy), .oht(oht),
        .o_vld(o_vld), .o_rdy(o_rdy), .bin(bin), .any(any), .err(err)
    );

    oht2bin_pipe #(.WIDTH(20), .SPLIT(4)) u_dut_b (
        .clk(clk), .rst(rst), .i_vld(i_vld_b), .i_rdy(i_rdy_b), .oht(oht_b),
        .o_vld(o_vld_b), .o_rdy(o_rdy_b), .bin(bin_b), .any(any_b), .err(err_b)
    );

    int   compared = 0, mismatched = 0;
    int   cyc = 0, n_in = 0, n_out = 0, first_in = 0, first_out = 0, last_out = 0;
    res_t exp_q[$];

    // Reference: the index is the OR of all set positions, and err means more than one bit was set.
    function automatic res_t ref_out(input logic [31:0] v);
        int         n = 0;
        logic [4:0] b = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                n++;
                b = b | 5'(i);
            end
        end
        return {ERR_ON && (n > 1), n != 0, b};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic reset_stats();
        cyc = 0; n_in = 0; n_out = 0; first_in = 0; first_out = 0; last_out = 0;
    endtask

    // One clock cycle on DUT a. Inputs are applied at the negedge. Transfers are
    // evaluated after settling, and the task then moves to the next negedge.
    task automatic step(input logic iv, input logic [31:0] d, input logic orr,
                        input bit use_exp, input res_t exp_in);
        res_t got;
        i_vld = iv; oht = d; o_rdy = orr;
        #1;
        if (!rst) begin
            if (i_vld && i_rdy) begin
                exp_q.push_back(use_exp ? exp_in : ref_out(d));
                if (n_in == 0) first_in = cyc;
                n_in++;
            end
            if (o_vld && o_rdy) begin
                if (n_out == 0) first_out = cyc;
                last_out = cyc;
                n_out++;
                got = {err, any, bin};
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL out_unexpected: got %0h expected no beat", got);
                end else begin
                    check("out_beat", 64'(got), 64'(exp_q.pop_front()));
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[8];
        tbl[0] = '{32'h0000_0001, {1'b0,   1'b1, 5'd0}};
        tbl[1] = '{32'h8000_0000, {1'b0,   1'b1, 5'd31}};
        tbl[2] = '{32'h0000_0000, {1'b0,   1'b0, 5'd0}};
        tbl[3] = '{32'h0001_0000, {1'b0,   1'b1, 5'd16}};
        tbl[4] = '{32'h0000_0110, {ERR_ON, 1'b1, 5'd12}};
        tbl[5] = '{32'h0000_0003, {ERR_ON, 1'b1, 5'd1}};
        tbl[6] = '{32'hFFFF_FFFF, {ERR_ON, 1'b1, 5'd31}};
        tbl[7] = '{32'h0000_0400, {1'b0,   1'b1, 5'd10}};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_state_a", {o_vld, i_rdy, any, err, bin}, {1'b0, 1'b1, 1'b0, 1'b0, 5'd0});
        check("reset_state_b", {o_vld_b, i_rdy_b, any_b, err_b, bin_b}, {1'b0, 1'b1, 1'b0, 1'b0, 5'd0});
        @(negedge clk);

        // Full-rate walking one. Checks latency and that there are no bubbles.
        reset_stats();
        for (int k = 0; k < 32; k++) step(1'b1, 32'h1 << k, 1'b1, 1'b0, '0);
        repeat (8) step(1'b0, '0, 1'b1, 1'b0, '0);
        check("walk_count", 64'(n_out), 64'd32);
        check("walk_latency", 64'(first_out - first_in), 64'd5);
        check("walk_no_bubble", 64'(last_out - first_out), 64'd31);

        // Table vectors with fixed expected results.
        reset_stats();
        for (int i = 0; i < 8; i++) step(1'b1, tbl[i].oht, 1'b1, 1'b1, tbl[i].exp);
        repeat (8) step(1'b0, '0, 1'b1, 1'b0, '0);
        check("table_count", 64'(n_out), 64'd8);

        // Backpressure: with o_rdy held low, exactly LEVELS beats are accepted.
        reset_stats();
        for (int c = 0; c < 12; c++) step(n_in < 8, 32'h8 << n_in, 1'b0, 1'b0, '0);
        check("bp_accepted", 64'(n_in), 64'd5);
        check("bp_i_rdy_low", 64'(i_rdy), 64'd0);
        for (int c = 0; c < 40; c++) step(n_in < 8, 32'h8 << n_in, 1'b1, 1'b0, '0);
        check("bp_drained", 64'(n_out), 64'd8);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // DUT b: padded tree (POWER=64) with 3-cycle latency.
        oht_b = 20'h8_0000; i_vld_b = 1'b1;
        #1 check("b_i_rdy", 64'(i_rdy_b), 64'd1);
        @(negedge clk);
        oht_b = 20'h0;
        @(negedge clk);
        i_vld_b = 1'b0;
        @(negedge clk);
        #1 check("b_bit19", {o_vld_b, any_b, err_b, bin_b}, {1'b1, 1'b1, 1'b0, 5'd19});
        @(negedge clk);
        #1 check("b_zero", {o_vld_b, any_b, err_b, bin_b}, {1'b1, 1'b0, 1'b0, 5'd0});
        @(negedge clk);
        #1 check("b_empty", 64'(o_vld_b), 64'd0);
        @(negedge clk);

        // Reset mid-stream discards the beats in flight.
        reset_stats();
        for (int k = 0; k < 3; k++) step(1'b1, 32'h4 << k, 1'b1, 1'b0, '0);
        rst = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0, '0);
        rst = 1'b0;
        #1;
        check("flush_state", {o_vld, i_rdy, bin}, {1'b0, 1'b1, 5'd0});
        exp_q.delete();
        reset_stats();
        repeat (10) step(1'b0, '0, 1'b1, 1'b0, '0);
        check("flush_no_ghosts", 64'(n_out), 64'd0);
        step(1'b1, 32'h80, 1'b1, 1'b0, '0);
        repeat (7) step(1'b0, '0, 1'b1, 1'b0, '0);
        check("flush_recover", 64'(n_out), 64'd1);

        // Random valid/ready traffic checked against the model.
        reset_stats();
        for (int c = 0; c < 60000 && n_out < 10000; c++) begin
            logic [31:0] d;
            int          r;
            r = $urandom_range(0, 9);
            if (r == 0)      d = '0;
            else if (r == 1) d = $urandom;
            else             d = 32'h1 << $urandom_range(0, 31);
            step((n_in < 10000) && ($urandom_range(0, 99) < 70), d,
                 $urandom_range(0, 99) < 70, 1'b0, '0);
        end
        check("rand_count", 64'(n_out), 64'd10000);
        check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

endmodule
